// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO.
// Frame format and bit period are latched per word at pop time.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  input  logic [DIV_W-1:0]              cfg_div_i,
  input  logic [1:0]                    cfg_len_i,
  input  logic [1:0]                    cfg_par_i,
  input  logic                          cfg_stop2_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     rptr_q;
  logic [LW-1:0]     level_q;
  logic              ovf_q;
  logic [DIV_W-1:0]  cnt_q;
  logic [DIV_W-1:0]  div_q;
  logic [1:0]        len_q;
  logic [1:0]        par_q;
  logic              stop2_q;
  logic [DATA_W-1:0] sh_q;
  logic [2:0]        idx_q;
  logic              pacc_q;
  logic              push;
  logic              pop;
  logic              tick;
  logic              last_bit;
  logic              par_en;

  assign full_o     = (level_q == LW'(FIFO_DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign overflow_o = ovf_q;
  assign busy_o     = (state_q != IDLE);

  assign push     = wr_en_i & ~full_o;
  assign tick     = (cnt_q == '0);
  assign last_bit = (idx_q == 3'd4 + {1'b0, len_q});
  assign par_en   = par_q[0] ^ par_q[1];

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop) level_q <= level_q + 1'b1;
      else if (!push && pop) level_q <= level_q - 1'b1;
      if (wr_en_i && full_o) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tx_o    = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!empty_o) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tx_o = 1'b0;
        if (tick) state_d = DATA;
      end
      DATA: begin
        tx_o = sh_q[0];
        if (tick && last_bit) state_d = par_en ? PARITY : STOP;
      end
      PARITY: begin
        // par_q[1] set means odd parity
        tx_o = pacc_q ^ par_q[1];
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick && (!stop2_q || idx_q[0])) begin
          if (!empty_o) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      div_q   <= '0;
      len_q   <= '0;
      par_q   <= '0;
      stop2_q <= 1'b0;
      sh_q    <= '0;
      idx_q   <= '0;
      pacc_q  <= 1'b0;
    end else if (pop) begin
      cnt_q   <= cfg_div_i;
      div_q   <= cfg_div_i;
      len_q   <= cfg_len_i;
      par_q   <= cfg_par_i;
      stop2_q <= cfg_stop2_i;
      sh_q    <= mem[rptr_q];
      idx_q   <= '0;
      pacc_q  <= 1'b0;
    end else if (state_q != IDLE) begin
      if (!tick) begin
        cnt_q <= cnt_q - 1'b1;
      end else begin
        cnt_q <= div_q;
        idx_q <= (state_d != state_q) ? 3'd0 : idx_q + 3'd1;
        if (state_q == DATA) begin
          pacc_q <= pacc_q ^ sh_q[0];
          sh_q   <= sh_q >> 1;
        end
      end
    end
  end

endmodule
